digit_scan_mux: RTL
===================

# digit_scan_mux

Time-multiplexed digit scanner sitting directly upstream of the hex-to-7-segment decoder on the FPGA display path. It holds a multi-nibble value, walks through the digits at a prescaled rate, and presents one 4-bit nibble per slot to the shared decoder. It also drives an active-low digit-enable bus. New values are double-buffered and applied only at frame boundaries, so a displayed frame never mixes old and new digits. Optional leading-zero blanking is supported.

## Interface
- N_DIGITS, 8: number of digits scanned; legal range 2..8.
- PRESCALE, 50000: clock cycles each digit stays active; legal minimum 1.
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  reset, asynchronous and active-low. One clock, no other clock domains.
- load_i  input  1  single-cycle strobe; capture data_i.
- data_i  input  4*N_DIGITS  value to display; nibble k (bits 4k+3:4k) is digit k, and digit 0 is the rightmost.
- blank_lz_i  input  1  enable leading-zero blanking; sampled every cycle.
- hex_o  output  4  nibble of the active digit; feeds the decoder's hex input.
- an_o  output  N_DIGITS  active-low digit enables, at most one bit low.
- digit_o  output  3  index of the digit currently scanned.
- frame_o  output  1  one-cycle pulse at frame wrap.
- pending_o  output  1  a loaded value is waiting for the next frame boundary.

## Operation
- Prescaler: counter pre runs 0..PRESCALE-1. tick is asserted when pre == PRESCALE-1; on tick, pre returns to 0.
- Digit index: idx advances only on tick. It counts modulo N_DIGITS, from N_DIGITS-1 back to 0.
- Wrap is defined as tick while idx == N_DIGITS-1.
- Buffering uses a shadow register shd, a display register disp, and a pending flag pend:
  - load_i without wrap: shd <= data_i and pend <= 1. Repeated loads overwrite shd, so the last load wins.
  - wrap with pend = 1 and no load_i: disp <= shd and pend <= 0.
  - load_i and wrap in the same cycle: disp <= data_i directly, pend <= 0, and shd <= data_i. The newest data wins.
  - wrap with pend = 0: disp is unchanged.
- Leading-zero blanking: digit k (k ≥ 1) is blanked when blank_lz_i = 1 and disp nibbles k..N_DIGITS-1 are all zero. Digit 0 is never blanked.
- Output for the slot idx:
  - hex_o = disp nibble idx.
  - digit_o = idx.
  - an_o = all ones with bit idx cleared. If the digit is blanked, an_o = all ones.
- frame_o = 1 in the cycle after a wrap edge.
- pending_o = pend.

## Timing
- Reset values: pre = 0, idx = 0, shd = 0, disp = 0, pend = 0.
- Output reset values: hex_o = 0, an_o = all ones, digit_o = 0, frame_o = 0, pending_o = 0.
- All outputs are registered and reflect state with one cycle of latency.
  - First clock after reset release: an_o = ~1 (digit 0 active) and hex_o = 0.
  - Digit k active cycles: each digit is active for exactly PRESCALE cycles.
  - Frame period: exactly N_DIGITS*PRESCALE cycles.
- Load latency:
  - pending_o rises 1 cycle after load_i.
  - The new digits appear on hex_o 1 cycle after the next wrap edge, at which point digit 0 is shown first.
- PRESCALE = 1: tick is asserted every cycle, so the index advances every clock.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous), and any pending value is discarded. The scan restarts at digit 0 on the first edge after release.
- blank_lz_i changes take effect on an_o in the next cycle, with no frame alignment.

## Test plan
- Reset and scan order (N_DIGITS = 4, PRESCALE = 4, no load):
  - an_o sequence is 1110, 1111, 1111, 1111, each held 4 cycles.
  - Digits 1..3 read 1111 only if blank_lz_i = 1; with blank_lz_i = 0 the sequence is 1110, 1101, 1011, 0111.
  - frame_o pulses every 16 cycles, and hex_o = 0 throughout.
- Load mid-frame:
  - Stimulus: load data_i = 16'h1234 while digit 2 is active.
  - pending_o = 1 until the wrap.
  - Next frame: hex_o shows 4, 3, 2, 1 on digits 0..3, then pending_o = 0.
- Back-to-back loads: 16'hAAAA then 16'h00C5 before the wrap → the next frame shows 5, C, then digits 2 and 3 blanked (an_o = 1111) with blank_lz_i = 1.
- Load coincident with wrap: data_i = 16'hBEEF on the wrap cycle → the frame starting immediately shows F, E, E, B, with pending_o never rising.
- Reset mid-operation: assert rst_ni = 0 for 1 cycle during digit 3 with pend = 1 → outputs return to reset values at once, pending_o = 0, and the old disp is lost (hex_o = 0).
- PRESCALE = 1, N_DIGITS = 8: digit_o steps 0..7 every cycle and frame_o pulses every 8 cycles.

Source files
------------

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner feeding a shared hex-to-7-segment decoder.
// New values are double-buffered and swapped in only at frame wrap.
module digit_scan_mux #(
    parameter int N_DIGITS = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic                  blank_lz_i,
    output logic [3:0]            hex_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [2:0]            digit_o,
    output logic                  frame_o,
    output logic                  pending_o
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [2:0] IDX_LAST = 3'(N_DIGITS - 1);

    logic [PRE_W-1:0]      pre_reg;
    logic [2:0]            idx_reg;
    logic [4*N_DIGITS-1:0] shd_reg;
    logic [4*N_DIGITS-1:0] disp_reg;
    logic                  pend_reg;
    logic [3:0]            hex_reg;
    logic [N_DIGITS-1:0]   an_reg;
    logic [2:0]            digit_reg;
    logic                  frame_reg;

    logic                  tick;
    logic                  wrap;
    logic                  blanked;
    logic [3:0]            nib [8];
    logic [7:0]            upper_zero;
    logic [N_DIGITS-1:0]   an_next;

    assign tick = (pre_reg == PRE_LAST);
    assign wrap = tick && (idx_reg == IDX_LAST);

    // Pad the nibble view to eight slots so the 3-bit index never selects out of range.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            if (gi < N_DIGITS) begin : g_used
                assign nib[gi] = disp_reg[4*gi +: 4];
            end else begin : g_pad
                assign nib[gi] = 4'h0;
            end
        end
    endgenerate

    // upper_zero[k]: every displayed nibble from k upward is zero.
    always_comb begin
        upper_zero[7] = (nib[7] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            upper_zero[k] = (nib[k] == 4'h0) && upper_zero[k+1];
        end
    end

    assign blanked = blank_lz_i && (idx_reg != 3'd0) && upper_zero[idx_reg];

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_an
            assign an_next[gi] = !((idx_reg == 3'(gi)) && !blanked);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_reg   <= '0;
            idx_reg   <= '0;
            shd_reg   <= '0;
            disp_reg  <= '0;
            pend_reg  <= 1'b0;
            hex_reg   <= 4'h0;
            an_reg    <= '1;
            digit_reg <= 3'd0;
            frame_reg <= 1'b0;
        end else begin
            if (tick) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                pre_reg <= pre_reg + PRE_W'(1);
            end

            // A load landing on the wrap bypasses the shadow so the newest data shows at once.
            if (load_i) begin
                shd_reg <= data_i;
                if (wrap) begin
                    disp_reg <= data_i;
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= 1'b1;
                end
            end else if (wrap && pend_reg) begin
                disp_reg <= shd_reg;
                pend_reg <= 1'b0;
            end

            hex_reg   <= nib[idx_reg];
            an_reg    <= an_next;
            digit_reg <= idx_reg;
            frame_reg <= wrap;
        end
    end

    assign hex_o     = hex_reg;
    assign an_o      = an_reg;
    assign digit_o   = digit_reg;
    assign frame_o   = frame_reg;
    assign pending_o = pend_reg;
endmodule
